// File: rtl/div_pkg.sv
// Shared types and helpers for the div32 restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [DIV_WIDTH-1:0] cneg(input logic [DIV_WIDTH-1:0] v,
                                                 input logic                 neg);
        return neg ? (~v + DIV_WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         din,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_nxt,
    output logic         qbit
);

    logic [W:0] trial;

    assign trial = {rem, din};
    // Trial value is W+1 bits; when it is >= divisor the difference fits in W bits.
    assign qbit    = (trial >= {1'b0, dvs});
    assign rem_nxt = qbit ? (trial[W-1:0] - dvs) : trial[W-1:0];

endmodule

// File: rtl/div32.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), C = {remainder, quotient}.
// Optional DIV_EARLY_TERM_EN: skip iterations when |S2| == 0 or |S1| < |S2|.
module div32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 sig,
    input  logic                 cancel,
    input  logic [WIDTH-1:0]     S1,
    input  logic [WIDTH-1:0]     S2,
    output logic [2*WIDTH-1:0]   C,
    output logic                 busy,
    output logic                 done
);

    div_state_t             state;
    logic [WIDTH-1:0]       rem;
    logic [WIDTH-1:0]       quo;
    logic [WIDTH-1:0]       dvs;
    logic [DIV_CNT_W-1:0]   cnt;
    logic                   qsign;
    logic                   rsign;

    logic [WIDTH-1:0]       a1;
    logic [WIDTH-1:0]       a2;
    logic [WIDTH-1:0]       rem_nxt;
    logic                   qbit;

    assign a1 = cneg(S1, sig & S1[WIDTH-1]);
    assign a2 = cneg(S2, sig & S2[WIDTH-1]);

    // quo holds the remaining dividend bits and collects quotient bits from the LSB end.
    div_step #(.W(WIDTH)) u_step (
        .rem     (rem),
        .din     (quo[WIDTH-1]),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

`ifdef DIV_EARLY_TERM_EN
    logic early;
    assign early = (a2 == '0) || (a1 < a2);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            C     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                // DONE also accepts a start so back-to-back ops run every 34 cycles.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (en) begin
                        dvs   <= a2;
                        qsign <= sig & (S1[WIDTH-1] ^ S2[WIDTH-1]);
                        rsign <= sig & S1[WIDTH-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef DIV_EARLY_TERM_EN
                        if (early) begin
                            rem   <= a1;
                            quo   <= (a2 == '0) ? '1 : '0;
                            state <= FIX;
                        end else begin
                            rem   <= '0;
                            quo   <= a1;
                            state <= CALC;
                        end
`else
                        rem   <= '0;
                        quo   <= a1;
                        state <= CALC;
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], qbit};
                    cnt <= cnt + DIV_CNT_W'(1);
                    if (cnt == DIV_CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    C     <= {cneg(rem, rsign), cneg(quo, qsign)};
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div32.sv
// Directed self-checking bench for div32.
module tb_div32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic        sig;
    logic        cancel;
    logic [31:0] S1;
    logic [31:0] S2;
    logic [63:0] C;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

`ifdef DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    div32 dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .sig    (sig),
        .cancel (cancel),
        .S1     (S1),
        .S2     (S2),
        .C      (C),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; k is the edge index after E0, 0 on timeout.
    task automatic wait_done(input int from, output int k);
        k = 0;
        for (int i = from; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input bit early_ok);
        int lat;
        int want;
        want = (EARLY && early_ok) ? 1 : 33;
        @(negedge clk);
        sig = s; S1 = a; S2 = b; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; S1 = $urandom; S2 = $urandom; sig = 1'b0;
        chk({tag, "/busy"}, 64'(busy), 64'(1));
        wait_done(1, lat);
        chk({tag, "/lat"}, 64'(lat), 64'(want));
        chk({tag, "/C"}, C, exp);
        @(posedge clk); #1;
        chk({tag, "/done1cyc"}, 64'(done), 64'(0));
        chk({tag, "/idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int lat;
        int nd;
        logic [63:0] exp_c [3];
        int          exp_t [3];

        resetn = 1'b0; en = 1'b0; sig = 1'b0; cancel = 1'b0; S1 = '0; S2 = '0;
        #12;
        chk("rst/C", C, 64'h0);
        chk("rst/busy", 64'(busy), 64'(0));
        chk("rst/done", 64'(done), 64'(0));
        @(negedge clk); resetn = 1'b1;

        run("divu100_7",  1'b0, 32'd100,       32'd7,          {32'd2, 32'd14},               1'b0);
        run("div-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},  1'b0);
        run("div7_-2",    1'b1, 32'd7,         32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD},  1'b0);
        run("ovf",        1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h0, 32'h80000000},         1'b0);
        run("divuMax_1",  1'b0, 32'hFFFFFFFF,  32'd1,          {32'h0, 32'hFFFFFFFF},         1'b0);
        run("divu5_0",    1'b0, 32'd5,         32'd0,          {32'd5, 32'hFFFFFFFF},         1'b1);
        run("div-5_0",    1'b1, 32'hFFFFFFFB,  32'd0,          {32'hFFFFFFFB, 32'h00000001},  1'b1);
        run("divu3_10",   1'b0, 32'd3,         32'd10,         {32'd3, 32'd0},                1'b1);
        run("div-3_10",   1'b1, 32'hFFFFFFFD,  32'd10,         {32'hFFFFFFFD, 32'd0},         1'b1);

        // en pulse while busy must be ignored
        @(negedge clk); sig = 1'b0; S1 = 32'd100; S2 = 32'd7; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        repeat (4) @(posedge clk);
        #1; en = 1'b1; S1 = 32'd9; S2 = 32'd3;
        @(posedge clk); #1; en = 1'b0;
        wait_done(6, lat);
        chk("busyen/lat", 64'(lat), 64'(33));
        chk("busyen/C", C, {32'd2, 32'd14});
        @(posedge clk); #1;
        chk("busyen/idle", 64'(busy), 64'(0));

        // cancel and en together in IDLE: cancel wins
        @(negedge clk); S1 = 32'd50; S2 = 32'd5; en = 1'b1; cancel = 1'b1;
        @(posedge clk); #1; en = 1'b0; cancel = 1'b0;
        chk("canceln/busy", 64'(busy), 64'(0));

        // cancel mid-CALC
        @(negedge clk); S1 = 32'd1000; S2 = 32'd3; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        repeat (9) @(posedge clk);
        #1; cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        chk("cancel/busy", 64'(busy), 64'(0));
        chk("cancel/done", 64'(done), 64'(0));
        chk("cancel/C", C, {32'd2, 32'd14});
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("cancel/nodone", 64'(nd), 64'(0));
        run("aftercancel", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0);

        // async reset mid-CALC
        @(negedge clk); S1 = 32'd77; S2 = 32'd5; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        repeat (5) @(posedge clk);
        #2; resetn = 1'b0;
        #1;
        chk("rstmid/C", C, 64'h0);
        chk("rstmid/busy", 64'(busy), 64'(0));
        chk("rstmid/done", 64'(done), 64'(0));
        @(negedge clk); resetn = 1'b1;

        // back-to-back with en held high; only E0/E34/E68 operands count
        exp_c[0] = {32'd2, 32'd14};             exp_t[0] = 33;
        exp_c[1] = {32'h0, 32'hFFFFFFFF};       exp_t[1] = 67;
        exp_c[2] = {32'hFFFFFFFF, 32'hFFFFFFFD}; exp_t[2] = 101;
        @(negedge clk); sig = 1'b0; S1 = 32'd100; S2 = 32'd7; en = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        for (int t = 1; t <= 101; t++) begin
            S1 = $urandom; S2 = $urandom; sig = 1'(($urandom));
            @(posedge clk); #1;
            if (done) begin
                if (nd < 3) begin
                    chk("b2b/t", 64'(t), 64'(exp_t[nd]));
                    chk("b2b/C", C, exp_c[nd]);
                end
                nd++;
            end
            if (t == 33) begin sig = 1'b0; S1 = 32'hFFFFFFFF; S2 = 32'd1; end
            if (t == 67) begin sig = 1'b1; S1 = 32'hFFFFFFF9; S2 = 32'd2; end
            if (t == 101) en = 1'b0;
            if (t == 33 || t == 67) begin
                @(posedge clk); #1;
                t++;
            end
        end
        chk("b2b/count", 64'(nd), 64'(3));
        @(posedge clk); #1;
        chk("b2b/idle", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
